// File: rtl/membus_initiator_if.sv
// Signal bundle between a command/response client, the membus_initiator and a MemSplit32 target.
// The master modport is the initiator's view; slave is the environment's view.
interface membus_initiator_if;
    // command channel
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_be_i;

    // response channel
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o;

    // MemSplit32 split-transaction bus
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_bo;
    logic [31:0] bus_wdata_bo;
    logic [3:0]  bus_be_bo;
    logic        bus_ack_i;
    logic        bus_resp_i;
    logic [31:0] bus_rdata_bi;

    logic        stray_resp_o;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_be_i,
        output cmd_ready_o,
        input  rsp_ready_i,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output bus_req_o, bus_we_o, bus_addr_bo, bus_wdata_bo, bus_be_bo,
        input  bus_ack_i, bus_resp_i, bus_rdata_bi,
        output stray_resp_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_be_i,
        input  cmd_ready_o,
        output rsp_ready_i,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  bus_req_o, bus_we_o, bus_addr_bo, bus_wdata_bo, bus_be_bo,
        output bus_ack_i, bus_resp_i, bus_rdata_bi,
        input  stray_resp_o
    );
endinterface

// File: rtl/membus_initiator.sv
// Single-outstanding MemSplit32 initiator: turns one command into a req/ack (+resp for reads)
// bus transaction with a shared REQ+WAIT_RESP timeout, and returns a held response.
module membus_initiator #(
    parameter int unsigned TIMEOUT = 100
) (
    input  logic               clk_gen,
    input  logic               srst,
    membus_initiator_if.master mb
);

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;

    // Counter can step one past TIMEOUT-1 when ack lands on the last REQ cycle.
    localparam int unsigned    CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          expired;

    logic          bus_req_q;
    logic          bus_we_q;
    logic [31:0]   bus_addr_q;
    logic [31:0]   bus_wdata_q;
    logic [3:0]    bus_be_q;

    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic [1:0]    rsp_err_q;
    logic          stray_q;

    assign cnt_d   = cnt_q + CW'(1);
    assign expired = (cnt_q >= TO_LAST);

    always_ff @(posedge clk_gen) begin
        if (srst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
            stray_q     <= 1'b0;
        end else begin
            // A response is only meaningful while waiting for one; anything else is flagged and dropped.
            if (mb.bus_resp_i && (state_q != S_WAIT)) begin
                stray_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (mb.cmd_valid_i) begin
                        if (mb.cmd_addr_i[1:0] != 2'b00) begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= ERR_MISALIGN;
                        end else begin
                            state_q     <= S_REQ;
                            cnt_q       <= '0;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= mb.cmd_we_i;
                            bus_addr_q  <= mb.cmd_addr_i;
                            bus_wdata_q <= mb.cmd_wdata_i;
                            bus_be_q    <= mb.cmd_be_i;
                        end
                    end
                end

                S_REQ: begin
                    cnt_q <= cnt_d;
                    if (mb.bus_ack_i || expired) begin
                        bus_req_q   <= 1'b0;
                        bus_wdata_q <= '0;
                        bus_be_q    <= '0;
                    end
                    // Ack on the final budget cycle still counts as success.
                    if (mb.bus_ack_i) begin
                        if (bus_we_q) begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= ERR_OK;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else if (expired) begin
                        state_q     <= S_DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= ERR_TIMEOUT;
                    end
                end

                S_WAIT: begin
                    cnt_q <= cnt_d;
                    if (mb.bus_resp_i) begin
                        state_q     <= S_DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= mb.bus_rdata_bi;
                        rsp_err_q   <= ERR_OK;
                    end else if (expired) begin
                        state_q     <= S_DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= ERR_TIMEOUT;
                    end
                end

                S_DONE: begin
                    if (mb.rsp_ready_i) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mb.cmd_ready_o  = (state_q == S_IDLE);

    assign mb.rsp_valid_o  = rsp_valid_q;
    assign mb.rsp_rdata_o  = rsp_rdata_q;
    assign mb.rsp_err_o    = rsp_err_q;

    assign mb.bus_req_o    = bus_req_q;
    assign mb.bus_we_o     = bus_we_q;
    assign mb.bus_addr_bo  = bus_addr_q;
    assign mb.bus_wdata_bo = bus_wdata_q;
    assign mb.bus_be_bo    = bus_be_q;

    assign mb.stray_resp_o = stray_q;

endmodule

// File: tb/tb_membus_initiator.sv
// Self-checking bench for membus_initiator: directed corner cases plus randomized commands
// scored against a cycle-count model of the command/bus/response rules.
`timescale 1ns/1ps
module tb_membus_initiator;

    localparam int TO = 100;

    logic clk_gen = 1'b0;
    logic srst    = 1'b1;

    membus_initiator_if mb ();

    membus_initiator #(.TIMEOUT(TO)) dut (
        .clk_gen (clk_gen),
        .srst    (srst),
        .mb      (mb)
    );

    always #5 clk_gen = ~clk_gen;

    int n_pass   = 0;
    int n_checks = 0;
    bit exp_stray = 1'b0;

    task automatic tick();
        @(posedge clk_gen);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(mb.cmd_ready_o), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(mb.rsp_valid_o), 32'd0);
        chk({tag, "_rsp_rdata"}, mb.rsp_rdata_o, 32'd0);
        chk({tag, "_rsp_err"}, 32'(mb.rsp_err_o), 32'd0);
        chk({tag, "_bus_req"}, 32'(mb.bus_req_o), 32'd0);
        chk({tag, "_bus_we"}, 32'(mb.bus_we_o), 32'd0);
        chk({tag, "_bus_addr"}, mb.bus_addr_bo, 32'd0);
        chk({tag, "_bus_wdata"}, mb.bus_wdata_bo, 32'd0);
        chk({tag, "_bus_be"}, 32'(mb.bus_be_bo), 32'd0);
        chk({tag, "_stray"}, 32'(mb.stray_resp_o), 32'd0);
    endtask

    // One full command: offer it, act as the bus target with the given ack/resp delays
    // (cycles counted from the first REQ cycle), then hold off rsp_ready for rdy_dly cycles.
    task automatic run_cmd(input string tag, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input int ack_dly, input int resp_dly, input logic [31:0] rdata,
                           input int rdy_dly, input bit resp_with_ack);
        int          exp_req;
        int          exp_done;
        logic [1:0]  exp_err;
        logic [31:0] exp_rdata;
        int          t;
        int          req_cnt;
        bit          done;
        bit          req_ok;
        bit          hold_ok;
        bit          aligned;

        aligned = (addr[1:0] == 2'b00);
        if (!aligned) begin
            exp_err = 2'b10; exp_rdata = '0; exp_req = 0; exp_done = 0;
        end else if (ack_dly > TO - 1) begin
            exp_err = 2'b01; exp_rdata = '0; exp_req = TO; exp_done = TO;
        end else if (we) begin
            exp_err = 2'b00; exp_rdata = '0; exp_req = ack_dly + 1; exp_done = ack_dly + 1;
        end else if (ack_dly + resp_dly > TO - 1) begin
            exp_err = 2'b01; exp_rdata = '0; exp_req = ack_dly + 1; exp_done = TO;
        end else begin
            exp_err = 2'b00; exp_rdata = rdata; exp_req = ack_dly + 1;
            exp_done = ack_dly + resp_dly + 1;
        end
        if (resp_with_ack && aligned && ack_dly <= TO - 1) exp_stray = 1'b1;

        chk({tag, "_ready_before"}, 32'(mb.cmd_ready_o), 32'd1);
        mb.cmd_valid_i = 1'b1;
        mb.cmd_we_i    = we;
        mb.cmd_addr_i  = addr;
        mb.cmd_wdata_i = wdata;
        mb.cmd_be_i    = be;
        tick();
        mb.cmd_valid_i = 1'b0;
        mb.cmd_we_i    = $urandom;
        mb.cmd_addr_i  = $urandom;
        mb.cmd_wdata_i = $urandom;
        mb.cmd_be_i    = $urandom;

        t = 0; req_cnt = 0; done = 1'b0; req_ok = 1'b1;
        while (!done && t < TO + 20) begin
            mb.bus_ack_i    = 1'b0;
            mb.bus_resp_i   = 1'b0;
            mb.bus_rdata_bi = $urandom;
            if (mb.rsp_valid_o) begin
                done = 1'b1;
            end else begin
                if (mb.cmd_ready_o) req_ok = 1'b0;
                if (mb.bus_req_o) begin
                    req_cnt++;
                    if (mb.bus_addr_bo !== addr || mb.bus_wdata_bo !== wdata ||
                        mb.bus_be_bo !== be || mb.bus_we_o !== we) req_ok = 1'b0;
                end else if (mb.bus_be_bo !== 4'd0 || mb.bus_wdata_bo !== 32'd0) begin
                    req_ok = 1'b0;
                end
                mb.bus_ack_i  = (t == ack_dly);
                mb.bus_resp_i = (!we && t == ack_dly + resp_dly) || (resp_with_ack && t == ack_dly);
                if (!we && t == ack_dly + resp_dly) mb.bus_rdata_bi = rdata;
                tick();
                t++;
            end
        end

        chk({tag, "_rsp_arrived"}, 32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(t), 32'(exp_done));
        chk({tag, "_req_cycles"}, 32'(req_cnt), 32'(exp_req));
        chk({tag, "_req_fields"}, 32'(req_ok), 32'd1);
        chk({tag, "_err"}, 32'(mb.rsp_err_o), 32'(exp_err));
        chk({tag, "_rdata"}, mb.rsp_rdata_o, exp_rdata);
        chk({tag, "_req_low_done"}, 32'(mb.bus_req_o), 32'd0);

        hold_ok = 1'b1;
        for (int i = 0; i < rdy_dly; i++) begin
            tick();
            if (mb.rsp_valid_o !== 1'b1 || mb.rsp_err_o !== exp_err ||
                mb.rsp_rdata_o !== exp_rdata || mb.cmd_ready_o !== 1'b0) hold_ok = 1'b0;
        end
        chk({tag, "_rsp_hold"}, 32'(hold_ok), 32'd1);

        mb.rsp_ready_i = 1'b1;
        tick();
        mb.rsp_ready_i = 1'b0;
        chk({tag, "_ready_after"}, 32'(mb.cmd_ready_o), 32'd1);
        chk({tag, "_valid_after"}, 32'(mb.rsp_valid_o), 32'd0);
        chk({tag, "_stray"}, 32'(mb.stray_resp_o), 32'(exp_stray));
        $display("txn %s we=%0d addr=%08h ack=%0d resp=%0d err=%0d rdata=%08h lat=%0d",
                 tag, we, addr, ack_dly, resp_dly, mb.rsp_err_o, mb.rsp_rdata_o, t);
    endtask

    initial begin
        bit          we;
        logic [31:0] addr;
        int          ack_dly;
        int          resp_dly;

        mb.cmd_valid_i  = 1'b0;
        mb.cmd_we_i     = 1'b0;
        mb.cmd_addr_i   = '0;
        mb.cmd_wdata_i  = '0;
        mb.cmd_be_i     = '0;
        mb.rsp_ready_i  = 1'b0;
        mb.bus_ack_i    = 1'b0;
        mb.bus_resp_i   = 1'b0;
        mb.bus_rdata_bi = '0;

        // reset
        srst = 1'b1;
        repeat (3) tick();
        srst = 1'b0;
        chk_reset_outputs("reset");

        // srst wins over a simultaneous command
        srst = 1'b1;
        mb.cmd_valid_i = 1'b1; mb.cmd_we_i = 1'b1; mb.cmd_addr_i = 32'h40;
        mb.cmd_wdata_i = 32'hFFFF_FFFF; mb.cmd_be_i = 4'hF;
        tick();
        srst = 1'b0; mb.cmd_valid_i = 1'b0;
        chk_reset_outputs("srst_prio");

        run_cmd("wr_immediate", 1'b1, 32'h0000_0000, 32'h0000_A5A5, 4'hF, 0, 0, 32'd0, 0, 1'b0);
        run_cmd("rd_ack2_resp1", 1'b0, 32'h8000_0010, 32'h0, 4'hF, 2, 1, 32'h1234_5678, 0, 1'b0);
        run_cmd("rd_no_ack", 1'b0, 32'h0000_0100, 32'h0, 4'hF, 100000, 1, 32'hDEAD_BEEF, 0, 1'b0);
        run_cmd("wr_no_ack", 1'b1, 32'h0000_0104, 32'h55AA_55AA, 4'h3, 100000, 0, 32'd0, 0, 1'b0);
        run_cmd("wr_ack_last", 1'b1, 32'h0000_0108, 32'h0BAD_F00D, 4'hC, TO - 1, 0, 32'd0, 0, 1'b0);
        run_cmd("rd_resp_last", 1'b0, 32'h0000_0200, 32'h0, 4'hF, 5, TO - 6, 32'hCAFE_0001, 0, 1'b0);
        run_cmd("rd_resp_late", 1'b0, 32'h0000_0204, 32'h0, 4'hF, 5, TO - 5, 32'hCAFE_0002, 0, 1'b0);
        run_cmd("rd_misaligned", 1'b0, 32'h0000_0006, 32'h0, 4'hF, 0, 1, 32'hCAFE_0003, 0, 1'b0);
        run_cmd("rd_hold5", 1'b0, 32'h0000_0300, 32'h0, 4'hF, 1, 2, 32'hA1B2_C3D4, 5, 1'b0);

        // response during the ack cycle is stray and ignored; the real one follows
        run_cmd("rd_resp_at_ack", 1'b0, 32'h0000_0400, 32'h0, 4'hF, 0, 2, 32'h7777_1111, 0, 1'b1);

        // stray response in IDLE is sticky until srst
        srst = 1'b1; tick(); srst = 1'b0; exp_stray = 1'b0;
        chk_reset_outputs("reset2");
        mb.bus_resp_i = 1'b1; tick(); mb.bus_resp_i = 1'b0;
        exp_stray = 1'b1;
        chk("stray_idle", 32'(mb.stray_resp_o), 32'd1);
        run_cmd("wr_after_stray", 1'b1, 32'h0000_0500, 32'h1, 4'h1, 1, 0, 32'd0, 2, 1'b0);

        // srst while waiting for a read response
        mb.cmd_valid_i = 1'b1; mb.cmd_we_i = 1'b0; mb.cmd_addr_i = 32'h0000_0600; mb.cmd_be_i = 4'hF;
        tick();
        mb.cmd_valid_i = 1'b0; mb.bus_ack_i = 1'b1;
        tick();
        mb.bus_ack_i = 1'b0;
        tick();
        srst = 1'b1; tick(); srst = 1'b0; exp_stray = 1'b0;
        chk_reset_outputs("srst_wait");
        repeat (2) tick();
        chk("srst_wait_no_rsp", 32'(mb.rsp_valid_o), 32'd0);
        mb.bus_resp_i = 1'b1; mb.bus_rdata_bi = 32'h9999_9999; tick(); mb.bus_resp_i = 1'b0;
        exp_stray = 1'b1;
        chk("late_resp_stray", 32'(mb.stray_resp_o), 32'd1);
        chk("late_resp_no_rsp", 32'(mb.rsp_valid_o), 32'd0);
        srst = 1'b1; tick(); srst = 1'b0; exp_stray = 1'b0;
        chk_reset_outputs("reset3");

        // randomized commands
        for (int n = 0; n < 30; n++) begin
            we   = 1'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 5) != 0) addr[1:0] = 2'b00;
            ack_dly  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(90, 130))
                                                   : int'($urandom_range(0, 6));
            if (!we && ack_dly == TO - 1) ack_dly = TO - 2;
            resp_dly = ($urandom_range(0, 4) == 0) ? int'($urandom_range(85, 110))
                                                   : int'($urandom_range(1, 5));
            run_cmd($sformatf("rand%0d", n), we, addr, $urandom, 4'($urandom),
                    ack_dly, resp_dly, $urandom, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/membus_initiator.md
MEMBUS_INITIATOR -- requirements
Module: membus_initiator

Interface
REQ-001 Parameter TIMEOUT, default 100, SHALL set the max cycles spent in REQ+WAIT_RESP before abort (legal range 2..2^24).
REQ-002 clk_gen  in  1  clock; all logic SHALL be on its rising edge.
REQ-003 srst  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid_i  in  1  command offered.
REQ-005 cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
REQ-006 cmd_we_i  in  1  1=write, 0=read.
REQ-007 cmd_addr_i  in  32  byte address.
REQ-008 cmd_wdata_i  in  32  write data.
REQ-009 cmd_be_i  in  4  byte enables.
REQ-010 rsp_valid_o  out  1  result available.
REQ-011 rsp_ready_i  in  1  result consumed when high together with rsp_valid_o.
REQ-012 rsp_rdata_o  out  32  read data (0 for writes and errors).
REQ-013 rsp_err_o  out  2  00=ok, 01=timeout, 10=misaligned.
REQ-014 bus_req_o, bus_we_o  out  1 each  MemSplit32 master request and direction.
REQ-015 bus_addr_bo, bus_wdata_bo  out  32 each; bus_be_bo  out  4.
REQ-016 bus_ack_i, bus_resp_i  in  1 each; bus_rdata_bi  in  32.
REQ-017 stray_resp_o  out  1  sticky flag: bus_resp_i seen outside WAIT_RESP.

Function
REQ-018 FSM states IDLE, REQ, WAIT_RESP, DONE; one command outstanding at most.
REQ-019 cmd_ready_o SHALL equal (state==IDLE), combinationally.
REQ-020 On accept: if cmd_addr_i[1:0]!=0, go to DONE with err=10 and no bus activity; else register addr/we/wdata/be, clear timeout counter, go to REQ.
REQ-021 In REQ, bus_req_o=1 and bus address/data/be/we SHALL hold the registered values, stable until ack.
REQ-022 In REQ with bus_ack_i=1: write -> DONE, err=00, rdata=0; read -> WAIT_RESP; bus_req_o SHALL drop the next cycle (single-cycle req when ack is immediate).
REQ-023 In WAIT_RESP with bus_resp_i=1: capture bus_rdata_bi into rsp_rdata_o, err=00, go to DONE.
REQ-024 Response SHALL be accepted no earlier than the cycle after ack; bus_resp_i in the ack cycle or in IDLE/DONE SHALL set stray_resp_o and be ignored.
REQ-025 Timeout counter SHALL increment every cycle in REQ and WAIT_RESP; when it equals TIMEOUT-1 and no ack (REQ) / resp (WAIT_RESP) that cycle, go to DONE with err=01, rdata=0, bus_req_o=0 next cycle.
REQ-026 Ack or resp arriving on the timeout cycle SHALL win over timeout.
REQ-027 In DONE, rsp_valid_o=1 and rsp_* held stable until rsp_ready_i=1; then IDLE next cycle.
REQ-028 Minimum throughput: accept (IDLE) -> REQ -> DONE for a write with immediate ack and rsp_ready_i=1 SHALL take 3 cycles per command.
REQ-029 bus_be_bo and bus_wdata_bo SHALL be driven 0 when bus_req_o=0; bus_addr_bo holds the last value.

Reset
REQ-030 srst SHALL force IDLE, bus_req_o=0, bus_we_o=0, bus_be_bo=0, bus_wdata_bo=0, bus_addr_bo=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=00, stray_resp_o=0, counter=0.
REQ-031 srst mid-transaction SHALL abort with no response; a late bus_resp_i after reset SHALL set stray_resp_o.
REQ-032 srst has priority over every other input in the same cycle.

Verification
REQ-033 Write 0x0000_0000 data 0x0000_A5A5 be=F, ack immediate -> one-cycle bus_req_o, rsp err=00 rdata=0, 3 cycles accept-to-next-ready.
REQ-034 Read 0x8000_0010, ack after 2 cycles, resp 1 cycle later with 0x1234_5678 -> rsp_rdata_o=0x1234_5678, err=00; req held stable 3 cycles.
REQ-035 TIMEOUT=100, read with ack never asserted -> after exactly 100 REQ cycles err=01, bus_req_o=0.
REQ-036 Read, ack, resp arriving on cycle TIMEOUT-1 -> err=00 with captured data; read addr 0x0000_0006 -> err=10, no bus_req_o ever.
REQ-037 rsp_ready_i low 5 cycles -> rsp_* stable, cmd_ready_o low throughout; resp pulse in IDLE -> stray_resp_o=1 until srst.
REQ-038 srst in WAIT_RESP -> all outputs at reset values next cycle, no rsp_valid_o.
